// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run/halt controller for a small CPU core. It holds the core in reset for a
// fixed number of cycles, then lets it run, halts it on stop requests,
// breakpoints, EBREAK or a watchdog timeout, and supports single stepping.
// It also keeps a saturating count of the cycles the core actually executed.
//
// Parameters
//   HOLD_CYCLES  cycles cpu_rst is held after any reset (1..255)
//   AUTO_START   1: go straight to RUN after the hold, 0: go to HALTED
//   WDOG_CYCLES  executed-cycle limit per run, 0 disables the watchdog
//
// Ports
//   i_clk         clock, all state updates on the rising edge
//   i_rst         asynchronous active-high reset
//   i_sw_rst      synchronous soft reset request (pulse)
//   i_start       resume execution request (pulse)
//   i_stop        halt request (pulse)
//   i_step        single-instruction request (pulse)
//   i_bp_en       breakpoint enable
//   i_bp_addr     breakpoint PC
//   i_pc          PC of the instruction executing this cycle
//   i_ebreak      CPU decodes EBREAK this cycle
//   o_cpu_rst     registered reset to the CPU
//   o_cpu_halt    combinational halt, 1 = CPU state frozen this cycle
//   o_running     1 while in RUN or STEP
//   o_halt_cause  0 none, 1 stop, 2 breakpoint, 3 ebreak, 4 watchdog, 5 step
//   o_cycle_cnt   executed cycles since the last reset
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned AUTO_START  = 1,
  parameter int unsigned WDOG_CYCLES = 5000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sw_rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_step,
  input  logic        i_bp_en,
  input  logic [31:0] i_bp_addr,
  input  logic [31:0] i_pc,
  input  logic        i_ebreak,
  output logic        o_cpu_rst,
  output logic        o_cpu_halt,
  output logic        o_running,
  output logic [2:0]  o_halt_cause,
  output logic [31:0] o_cycle_cnt
);

  localparam logic [1:0] ST_HOLD   = 2'd0;
  localparam logic [1:0] ST_HALTED = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_STEP   = 2'd3;

  localparam logic [2:0] CAUSE_NONE   = 3'd0;
  localparam logic [2:0] CAUSE_STOP   = 3'd1;
  localparam logic [2:0] CAUSE_BP     = 3'd2;
  localparam logic [2:0] CAUSE_EBREAK = 3'd3;
  localparam logic [2:0] CAUSE_WDOG   = 3'd4;
  localparam logic [2:0] CAUSE_STEP   = 3'd5;

  // Terminal values of the hold and watchdog counters (both count from 0).
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
  localparam bit          WDOG_ON   = (WDOG_CYCLES != 0);
  localparam bit          AUTO_RUN  = (AUTO_START != 0);

  logic [1:0]  r_state;
  logic [7:0]  r_hold_cnt;
  logic [31:0] r_wdog_cnt;
  logic        r_bp_skip;
  logic        r_cpu_rst;
  logic        r_running;
  logic [2:0]  r_halt_cause;
  logic [31:0] r_cycle_cnt;

  logic        w_in_run;
  logic        w_in_step;
  logic        w_bp_hit;
  logic        w_cpu_halt;
  logic        w_exec;
  logic        w_wdog_expire;
  logic        w_enter_run;
  logic [1:0]  w_next_state;
  logic [2:0]  w_next_cause;

  assign w_in_run  = (r_state == ST_RUN);
  assign w_in_step = (r_state == ST_STEP);

  // bp_skip masks the breakpoint for the first RUN cycle so that resuming
  // from a breakpoint executes the instruction sitting on bp_addr once.
  assign w_bp_hit   = w_in_run && i_bp_en && (i_pc == i_bp_addr) && !r_bp_skip;
  assign w_cpu_halt = !(w_in_run || w_in_step) || w_bp_hit;
  assign w_exec     = !w_cpu_halt && !r_cpu_rst;

  // The cycle that reaches the limit still executes; the halt follows it.
  assign w_wdog_expire = WDOG_ON && w_in_run && w_exec && (r_wdog_cnt == WDOG_LAST);

  // Next-state and halt-cause decode; soft reset overrides everything.
  always_comb begin
    w_next_state = r_state;
    w_next_cause = r_halt_cause;
    if (i_sw_rst) begin
      w_next_state = ST_HOLD;
      w_next_cause = CAUSE_NONE;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_next_state = AUTO_RUN ? ST_RUN : ST_HALTED;
            w_next_cause = CAUSE_NONE;
          end
        end
        ST_HALTED: begin
          if (i_start)     w_next_state = ST_RUN;
          else if (i_step) w_next_state = ST_STEP;
        end
        ST_RUN: begin
          if (w_bp_hit) begin
            w_next_state = ST_HALTED;
            w_next_cause = CAUSE_BP;
          end else if (i_ebreak) begin
            w_next_state = ST_HALTED;
            w_next_cause = CAUSE_EBREAK;
          end else if (i_stop) begin
            w_next_state = ST_HALTED;
            w_next_cause = CAUSE_STOP;
          end else if (w_wdog_expire) begin
            w_next_state = ST_HALTED;
            w_next_cause = CAUSE_WDOG;
          end
        end
        ST_STEP: begin
          w_next_state = ST_HALTED;
          w_next_cause = i_ebreak ? CAUSE_EBREAK : CAUSE_STEP;
        end
        default: begin
          w_next_state = ST_HOLD;
          w_next_cause = CAUSE_NONE;
        end
      endcase
    end
  end

  assign w_enter_run = (w_next_state == ST_RUN) && !w_in_run;

  // State register plus the outputs that are registered from the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_HOLD;
      r_halt_cause <= CAUSE_NONE;
      r_cpu_rst    <= 1'b1;
      r_running    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_halt_cause <= w_next_cause;
      r_cpu_rst    <= (w_next_state == ST_HOLD);
      r_running    <= (w_next_state == ST_RUN) || (w_next_state == ST_STEP);
    end
  end

  // Hold counter restarts whenever HOLD is (re)entered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold_cnt <= 8'd0;
    end else if (i_sw_rst || (r_state != ST_HOLD)) begin
      r_hold_cnt <= 8'd0;
    end else begin
      r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end

  // Watchdog counter and breakpoint skip flag, both re-armed on entry to RUN.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wdog_cnt <= 32'd0;
      r_bp_skip  <= 1'b0;
    end else if (w_enter_run) begin
      r_wdog_cnt <= 32'd0;
      r_bp_skip  <= 1'b1;
    end else if (w_in_run) begin
      r_bp_skip <= 1'b0;
      if (w_exec) r_wdog_cnt <= r_wdog_cnt + 32'd1;
    end
  end

  // Saturating count of executed cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cycle_cnt <= 32'd0;
    end else if (i_sw_rst) begin
      r_cycle_cnt <= 32'd0;
    end else if (w_exec && (r_cycle_cnt != 32'hFFFF_FFFF)) begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end
  end

  assign o_cpu_rst    = r_cpu_rst;
  assign o_cpu_halt   = w_cpu_halt;
  assign o_running    = r_running;
  assign o_halt_cause = r_halt_cause;
  assign o_cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
//
// Bench for cpu_run_ctrl. Instance A (AUTO_START=0, HOLD_CYCLES=3) carries
// most scenarios; instance B (AUTO_START=1, WDOG_CYCLES=8) shares the inputs
// and is checked for auto-start and watchdog behaviour. Expected counts and
// causes are queued when stimulus is driven and popped when results appear.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, swRst, start, stop, step, bpEn, ebreak;
  logic [31:0] bpAddr, pc;

  logic        aCpuRst, aCpuHalt, aRunning;
  logic [2:0]  aHaltCause;
  logic [31:0] aCycleCnt;
  logic        bCpuRst, bCpuHalt, bRunning;
  logic [2:0]  bHaltCause;
  logic [31:0] bCycleCnt;

  int testsRun = 0;
  int testsFailed = 0;
  logic [31:0] expQ[$];
  logic [31:0] exp;

  cpu_run_ctrl #(.HOLD_CYCLES(3), .AUTO_START(0), .WDOG_CYCLES(5000)) dutA (
    .i_clk(clk), .i_rst(rst), .i_sw_rst(swRst), .i_start(start), .i_stop(stop),
    .i_step(step), .i_bp_en(bpEn), .i_bp_addr(bpAddr), .i_pc(pc), .i_ebreak(ebreak),
    .o_cpu_rst(aCpuRst), .o_cpu_halt(aCpuHalt), .o_running(aRunning),
    .o_halt_cause(aHaltCause), .o_cycle_cnt(aCycleCnt)
  );

  cpu_run_ctrl #(.HOLD_CYCLES(4), .AUTO_START(1), .WDOG_CYCLES(8)) dutB (
    .i_clk(clk), .i_rst(rst), .i_sw_rst(swRst), .i_start(start), .i_stop(stop),
    .i_step(step), .i_bp_en(bpEn), .i_bp_addr(bpAddr), .i_pc(pc), .i_ebreak(ebreak),
    .o_cpu_rst(bCpuRst), .o_cpu_halt(bCpuHalt), .o_running(bRunning),
    .o_halt_cause(bHaltCause), .o_cycle_cnt(bCycleCnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    swRst = 0; start = 0; stop = 0; step = 0; bpEn = 0; ebreak = 0;
    bpAddr = 32'd0; pc = 32'd0;
  endtask

  task automatic doSoftReset();
    swRst = 1;
    tick();
    swRst = 0;
    testsRun++;
    if (aCpuRst !== 1'b1 || aCycleCnt !== 32'd0 || aHaltCause !== 3'd0) begin
      testsFailed++;
      $display("[TB] FAIL sw_rst_clear: rst=%0b cnt=%0d cause=%0d expected 1/0/0", aCpuRst, aCycleCnt, aHaltCause);
    end
    repeat (5) tick();
    testsRun++;
    if (aCpuRst !== 1'b0 || aRunning !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL sw_rst_hold_end: rst=%0b running=%0b expected 0/0", aCpuRst, aRunning);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    applyStimulus();
    repeat (2) tick();
    testsRun++;
    if (aCpuRst !== 1'b1 || aCpuHalt !== 1'b1 || aRunning !== 1'b0 || aHaltCause !== 3'd0 || aCycleCnt !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_values: rst=%0b halt=%0b run=%0b cause=%0d cnt=%0d expected 1/1/0/0/0",
               aCpuRst, aCpuHalt, aRunning, aHaltCause, aCycleCnt);
    end
    rst = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      testsRun++;
      if (aCpuRst !== (i < 3)) begin
        testsFailed++;
        $display("[TB] FAIL hold_edge_%0d: cpu_rst=%0b expected %0b", i, aCpuRst, (i < 3));
      end
    end
    testsRun++;
    if (aCpuHalt !== 1'b1 || aHaltCause !== 3'd0 || aCycleCnt !== 32'd0 || aRunning !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL hold_to_halted: halt=%0b cause=%0d cnt=%0d run=%0b expected 1/0/0/0",
               aCpuHalt, aHaltCause, aCycleCnt, aRunning);
    end
    tick();
    testsRun++;
    if (bRunning !== 1'b1 || bCpuRst !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL auto_start: running=%0b cpu_rst=%0b expected 1/0", bRunning, bCpuRst);
    end
  endtask

  task automatic test_run_stop();
    start = 1;
    expQ.push_back(32'd11);
    expQ.push_back(32'd1);
    tick();
    start = 0;
    testsRun++;
    if (aRunning !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL start_running: got %0b expected 1", aRunning);
    end
    repeat (10) tick();
    stop = 1;
    #1;
    testsRun++;
    if (aCpuHalt !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL stop_cycle_exec: cpu_halt=%0b expected 0", aCpuHalt);
    end
    tick();
    stop = 0;
    exp = expQ.pop_front();
    testsRun++;
    if (aCycleCnt !== exp) begin
      testsFailed++;
      $display("[TB] FAIL run_stop_cnt: got %0d expected %0d", aCycleCnt, exp);
    end
    exp = expQ.pop_front();
    testsRun++;
    if (aHaltCause !== exp[2:0] || aCpuHalt !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL run_stop_cause: cause=%0d halt=%0b expected %0d/1", aHaltCause, aCpuHalt, exp);
    end
  endtask

  task automatic test_breakpoint();
    doSoftReset();
    bpEn = 1; bpAddr = 32'h10; pc = 32'h0;
    start = 1;
    expQ.push_back(32'd4);
    expQ.push_back(32'd2);
    tick();
    start = 0;
    for (int k = 0; k < 4; k++) begin
      pc = 32'(k * 4);
      tick();
    end
    pc = 32'h10;
    #1;
    testsRun++;
    if (aCpuHalt !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL bp_hit_halt: cpu_halt=%0b expected 1", aCpuHalt);
    end
    tick();
    exp = expQ.pop_front();
    testsRun++;
    if (aCycleCnt !== exp) begin
      testsFailed++;
      $display("[TB] FAIL bp_cnt: got %0d expected %0d", aCycleCnt, exp);
    end
    exp = expQ.pop_front();
    testsRun++;
    if (aHaltCause !== exp[2:0] || aRunning !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL bp_cause: cause=%0d running=%0b expected %0d/0", aHaltCause, aRunning, exp);
    end
    start = 1;
    tick();
    start = 0;
    #1;
    testsRun++;
    if (aCpuHalt !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL bp_resume_exec: cpu_halt=%0b expected 0", aCpuHalt);
    end
    expQ.push_back(32'd7);
    expQ.push_back(32'd1);
    tick();
    testsRun++;
    if (aRunning !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL bp_no_rehit: running=%0b expected 1", aRunning);
    end
    pc = 32'h14;
    tick();
    pc = 32'h18;
    stop = 1;
    tick();
    stop = 0;
    exp = expQ.pop_front();
    testsRun++;
    if (aCycleCnt !== exp) begin
      testsFailed++;
      $display("[TB] FAIL bp_resume_cnt: got %0d expected %0d", aCycleCnt, exp);
    end
    exp = expQ.pop_front();
    testsRun++;
    if (aHaltCause !== exp[2:0]) begin
      testsFailed++;
      $display("[TB] FAIL bp_resume_cause: got %0d expected %0d", aHaltCause, exp);
    end
    bpEn = 0;
    pc = 32'h0;
  endtask

  task automatic test_step();
    int execs;
    execs = 0;
    bpEn = 1; bpAddr = 32'h40; pc = 32'h40;
    expQ.push_back(32'd10);
    expQ.push_back(32'd5);
    for (int s = 0; s < 3; s++) begin
      step = 1;
      #1;
      if (!aCpuHalt) execs++;
      tick();
      step = 0;
      if (s == 1) stop = 1;
      #1;
      if (!aCpuHalt) execs++;
      tick();
      stop = 0;
      #1;
      if (!aCpuHalt) execs++;
      tick();
    end
    testsRun++;
    if (execs !== 3) begin
      testsFailed++;
      $display("[TB] FAIL step_exec_cycles: got %0d expected 3", execs);
    end
    exp = expQ.pop_front();
    testsRun++;
    if (aCycleCnt !== exp) begin
      testsFailed++;
      $display("[TB] FAIL step_cnt: got %0d expected %0d", aCycleCnt, exp);
    end
    exp = expQ.pop_front();
    testsRun++;
    if (aHaltCause !== exp[2:0]) begin
      testsFailed++;
      $display("[TB] FAIL step_cause: got %0d expected %0d", aHaltCause, exp);
    end
    bpEn = 0;
    pc = 32'h0;
  endtask

  task automatic test_start_step_coincide();
    start = 1;
    step = 1;
    expQ.push_back(32'd12);
    expQ.push_back(32'd1);
    tick();
    start = 0;
    step = 0;
    tick();
    testsRun++;
    if (aRunning !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL start_wins: running=%0b expected 1", aRunning);
    end
    stop = 1;
    tick();
    stop = 0;
    exp = expQ.pop_front();
    testsRun++;
    if (aCycleCnt !== exp) begin
      testsFailed++;
      $display("[TB] FAIL coincide_cnt: got %0d expected %0d", aCycleCnt, exp);
    end
    exp = expQ.pop_front();
    testsRun++;
    if (aHaltCause !== exp[2:0]) begin
      testsFailed++;
      $display("[TB] FAIL coincide_cause: got %0d expected %0d", aHaltCause, exp);
    end
  endtask

  task automatic test_ebreak_stop();
    start = 1;
    tick();
    start = 0;
    ebreak = 1;
    stop = 1;
    #1;
    testsRun++;
    if (aCpuHalt !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ebreak_cycle_exec: cpu_halt=%0b expected 0", aCpuHalt);
    end
    expQ.push_back(32'd13);
    expQ.push_back(32'd3);
    tick();
    ebreak = 0;
    stop = 0;
    exp = expQ.pop_front();
    testsRun++;
    if (aCycleCnt !== exp) begin
      testsFailed++;
      $display("[TB] FAIL ebreak_cnt: got %0d expected %0d", aCycleCnt, exp);
    end
    exp = expQ.pop_front();
    testsRun++;
    if (aHaltCause !== exp[2:0]) begin
      testsFailed++;
      $display("[TB] FAIL ebreak_over_stop: got %0d expected %0d", aHaltCause, exp);
    end
    step = 1;
    tick();
    step = 0;
    ebreak = 1;
    expQ.push_back(32'd14);
    expQ.push_back(32'd3);
    tick();
    ebreak = 0;
    exp = expQ.pop_front();
    testsRun++;
    if (aCycleCnt !== exp) begin
      testsFailed++;
      $display("[TB] FAIL step_ebreak_cnt: got %0d expected %0d", aCycleCnt, exp);
    end
    exp = expQ.pop_front();
    testsRun++;
    if (aHaltCause !== exp[2:0]) begin
      testsFailed++;
      $display("[TB] FAIL step_ebreak_cause: got %0d expected %0d", aHaltCause, exp);
    end
  endtask

  task automatic test_watchdog();
    int execs;
    doSoftReset();
    expQ.push_back(32'd8);
    expQ.push_back(32'd4);
    repeat (15) tick();
    exp = expQ.pop_front();
    testsRun++;
    if (bCycleCnt !== exp) begin
      testsFailed++;
      $display("[TB] FAIL wdog_auto_cnt: got %0d expected %0d", bCycleCnt, exp);
    end
    exp = expQ.pop_front();
    testsRun++;
    if (bHaltCause !== exp[2:0] || bCpuHalt !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL wdog_auto_cause: cause=%0d halt=%0b expected %0d/1", bHaltCause, bCpuHalt, exp);
    end
    execs = 0;
    start = 1;
    expQ.push_back(32'd16);
    expQ.push_back(32'd4);
    #1;
    if (!bCpuHalt) execs++;
    tick();
    start = 0;
    for (int c = 0; c < 20; c++) begin
      if (!bCpuHalt) execs++;
      tick();
    end
    testsRun++;
    if (execs !== 8) begin
      testsFailed++;
      $display("[TB] FAIL wdog_exec_cycles: got %0d expected 8", execs);
    end
    exp = expQ.pop_front();
    testsRun++;
    if (bCycleCnt !== exp) begin
      testsFailed++;
      $display("[TB] FAIL wdog_cnt: got %0d expected %0d", bCycleCnt, exp);
    end
    exp = expQ.pop_front();
    testsRun++;
    if (bHaltCause !== exp[2:0]) begin
      testsFailed++;
      $display("[TB] FAIL wdog_cause: got %0d expected %0d", bHaltCause, exp);
    end
    stop = 1;
    tick();
    stop = 0;
  endtask

  task automatic test_sw_rst();
    start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    swRst = 1;
    stop = 1;
    ebreak = 1;
    tick();
    swRst = 0;
    stop = 0;
    ebreak = 0;
    testsRun++;
    if (aCpuRst !== 1'b1 || aCycleCnt !== 32'd0 || aHaltCause !== 3'd0 || aRunning !== 1'b0 || aCpuHalt !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL sw_rst_mid_run: rst=%0b cnt=%0d cause=%0d run=%0b halt=%0b expected 1/0/0/0/1",
               aCpuRst, aCycleCnt, aHaltCause, aRunning, aCpuHalt);
    end
    repeat (3) tick();
    testsRun++;
    if (aCpuRst !== 1'b0 || aRunning !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL sw_rst_release: rst=%0b run=%0b expected 0/0", aCpuRst, aRunning);
    end
  endtask

  task automatic test_async_rst();
    start = 1;
    tick();
    start = 0;
    repeat (3) tick();
    testsRun++;
    if (aCpuHalt !== 1'b0 || aCycleCnt !== 32'd3) begin
      testsFailed++;
      $display("[TB] FAIL pre_async_run: halt=%0b cnt=%0d expected 0/3", aCpuHalt, aCycleCnt);
    end
    #2;
    rst = 1;
    #1;
    testsRun++;
    if (aCpuRst !== 1'b1 || aCpuHalt !== 1'b1 || aRunning !== 1'b0 || aCycleCnt !== 32'd0 || aHaltCause !== 3'd0) begin
      testsFailed++;
      $display("[TB] FAIL async_rst: rst=%0b halt=%0b run=%0b cnt=%0d cause=%0d expected 1/1/0/0/0",
               aCpuRst, aCpuHalt, aRunning, aCycleCnt, aHaltCause);
    end
    tick();
    rst = 0;
    repeat (4) tick();
    testsRun++;
    if (aCpuRst !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL async_rst_release: cpu_rst=%0b expected 0", aCpuRst);
    end
  endtask

  task automatic checkOutput();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
  endtask

  initial begin
    test_reset();
    test_run_stop();
    test_breakpoint();
    test_step();
    test_start_step_coincide();
    test_ebreak_stop();
    test_watchdog();
    test_sw_rst();
    test_async_rst();
    checkOutput();
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
